tile_buffer_bank: RTL

Parametrised tile buffer bank with NUM_BUFFERS independent buffers, each holding up to TILES_PER_BUFFER tiles. Writes and reads use valid/ready handshakes and per-buffer auto-increment or explicit tile addressing. Per-buffer fill tracking drives last-tile flags, underflow and overflow errors. Sits between the load/DMA path and the compute units, replacing the fixed two-type vector/matrix buffer files.

---
 rtl/tile_buffer_pkg.sv | 22 ++
 rtl/tile_ram.sv | 21 ++
 rtl/tile_buffer_bank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tile_buffer_pkg.sv
// Shared types and helpers for the tile buffer bank.
package tile_buffer_pkg;

  // Pointer/fill fields are sized for the largest supported buffer depth.
  localparam int unsigned PTR_W = 16;

  typedef struct packed {
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fill;
  } buf_state_t;

  typedef enum logic {
    AUTO     = 1'b0,
    EXPLICIT = 1'b1
  } access_mode_t;

  function automatic int unsigned tile_index_width(input int unsigned tiles);
    return (tiles > 1) ? $clog2(tiles) : 1;
  endfunction

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port tile RAM, registered read-first output; maps onto block RAM.
module tile_ram #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/tile_buffer_bank.sv
// Bank of independent tile buffers with per-buffer fill tracking and 2-cycle reads.
// Optional BUFCTRL_BYPASS_EN forwards a same-cycle same-tile write into the read.
module tile_buffer_bank
  import tile_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned TILE_ELEMS       = 32,
  parameter int unsigned NUM_BUFFERS      = 8,
  parameter int unsigned TILES_PER_BUFFER = 32,
  parameter int unsigned ID_WIDTH         = 5,
  localparam int unsigned TILE_WIDTH      = DATA_WIDTH * TILE_ELEMS,
  localparam int unsigned IDX_W           = tile_index_width(TILES_PER_BUFFER)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ID_WIDTH-1:0]   i_wr_id,
  input  logic                  i_wr_explicit,
  input  logic [IDX_W-1:0]      i_wr_addr,
  input  logic [TILE_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_req_valid,
  output logic                  o_rd_req_ready,
  input  logic [ID_WIDTH-1:0]   i_rd_id,
  input  logic                  i_rd_explicit,
  input  logic [IDX_W-1:0]      i_rd_addr,
  output logic [TILE_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_last,
  input  logic                  i_clr_valid,
  input  logic [ID_WIDTH-1:0]   i_clr_id,
  output logic                  o_err_id,
  output logic                  o_err_underflow,
  output logic                  o_err_overflow
);

  localparam int unsigned BUF_W  = tile_index_width(NUM_BUFFERS);
  localparam int unsigned ADDR_W = BUF_W + IDX_W;
  localparam logic [PTR_W-1:0] FULL = PTR_W'(TILES_PER_BUFFER);

  buf_state_t r_state   [NUM_BUFFERS];
  buf_state_t w_state_d [NUM_BUFFERS];

  logic                  r_s1_valid, r_s1_ok, r_s1_last;
  logic                  r_rd_valid, r_rd_last;
  logic [TILE_WIDTH-1:0] r_rd_data;
  logic                  r_err_id, r_err_unf, r_err_ovf;

  // Write side
  logic             w_wr_fire, w_wr_id_ok, w_wr_auto, w_wr_full, w_we, w_wr_ovf;
  logic [BUF_W-1:0] w_wr_buf;
  logic [IDX_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_wr_ptr, w_wr_fill, w_wr_idx_p1;

  assign w_wr_fire   = i_wr_valid && !i_clr_valid;
  assign w_wr_id_ok  = 32'(i_wr_id) < NUM_BUFFERS;
  assign w_wr_buf    = i_wr_id[BUF_W-1:0];
  assign w_wr_ptr    = r_state[w_wr_buf].wr_ptr;
  assign w_wr_fill   = r_state[w_wr_buf].fill;
  assign w_wr_auto   = access_mode_t'(i_wr_explicit) == AUTO;
  assign w_wr_full   = w_wr_ptr == FULL;
  assign w_wr_idx    = w_wr_auto ? w_wr_ptr[IDX_W-1:0] : i_wr_addr;
  assign w_wr_idx_p1 = PTR_W'(w_wr_idx) + PTR_W'(1);
  assign w_we        = w_wr_fire && w_wr_id_ok && !(w_wr_auto && w_wr_full);
  assign w_wr_ovf    = w_wr_fire && w_wr_id_ok && w_wr_auto && w_wr_full;

  // Read side; the underflow check sees only registered fill
  logic             w_rd_fire, w_rd_id_ok, w_rd_auto, w_rd_hit, w_rd_last, w_rd_ok, w_rd_unf;
  logic [BUF_W-1:0] w_rd_buf;
  logic [IDX_W-1:0] w_rd_idx;
  logic [PTR_W-1:0] w_rd_fill, w_rd_idx_ext, w_rd_inc;

  assign w_rd_fire    = i_rd_req_valid && !i_clr_valid;
  assign w_rd_id_ok   = 32'(i_rd_id) < NUM_BUFFERS;
  assign w_rd_buf     = i_rd_id[BUF_W-1:0];
  assign w_rd_fill    = r_state[w_rd_buf].fill;
  assign w_rd_auto    = access_mode_t'(i_rd_explicit) == AUTO;
  assign w_rd_idx     = w_rd_auto ? r_state[w_rd_buf].rd_ptr[IDX_W-1:0] : i_rd_addr;
  assign w_rd_idx_ext = PTR_W'(w_rd_idx);
  assign w_rd_inc     = w_rd_idx_ext + PTR_W'(1);
  assign w_rd_hit     = w_rd_idx_ext < w_rd_fill;
  assign w_rd_last    = w_rd_idx_ext == (w_rd_fill - PTR_W'(1));
  assign w_rd_ok      = w_rd_fire && w_rd_id_ok && w_rd_hit;
  assign w_rd_unf     = w_rd_fire && w_rd_id_ok && !w_rd_hit;

  logic             w_clr_id_ok;
  logic [BUF_W-1:0] w_clr_buf;

  assign w_clr_id_ok = 32'(i_clr_id) < NUM_BUFFERS;
  assign w_clr_buf   = i_clr_id[BUF_W-1:0];

  always_comb begin
    w_state_d = r_state;
    if (w_we) begin
      if (w_wr_auto) begin
        w_state_d[w_wr_buf].wr_ptr = w_wr_idx_p1;
        w_state_d[w_wr_buf].fill   = w_wr_idx_p1;
      end else if (w_wr_idx_p1 > w_wr_fill) begin
        w_state_d[w_wr_buf].fill = w_wr_idx_p1;
      end
    end
    // An out-of-range auto read leaves rd_ptr where it is
    if (w_rd_ok && w_rd_auto) begin
      w_state_d[w_rd_buf].rd_ptr = (w_rd_inc == w_rd_fill) ? '0 : w_rd_inc;
    end
    if (i_clr_valid && w_clr_id_ok) w_state_d[w_clr_buf] = '0;
  end

  logic [ADDR_W-1:0]     w_waddr, w_raddr;
  logic [TILE_WIDTH-1:0] w_ram_q, w_s1_data;

  assign w_waddr = {w_wr_buf, w_wr_idx};
  assign w_raddr = {w_rd_buf, w_rd_idx};

  tile_ram #(
    .WIDTH  (TILE_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_wr_data),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

`ifdef BUFCTRL_BYPASS_EN
  logic                  r_s1_byp;
  logic [TILE_WIDTH-1:0] r_s1_byp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_byp      <= 1'b0;
      r_s1_byp_data <= '0;
    end else begin
      r_s1_byp      <= w_we && w_rd_fire && w_rd_id_ok && (w_waddr == w_raddr);
      r_s1_byp_data <= i_wr_data;
    end
  end

  assign w_s1_data = r_s1_byp ? r_s1_byp_data : w_ram_q;
`else
  assign w_s1_data = w_ram_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) r_state[i] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_ok    <= 1'b0;
      r_s1_last  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_err_id   <= 1'b0;
      r_err_unf  <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_s1_valid <= w_rd_fire;
      r_s1_ok    <= w_rd_ok;
      r_s1_last  <= w_rd_last;
      r_rd_valid <= r_s1_valid;
      r_rd_last  <= r_s1_ok && r_s1_last;
      r_rd_data  <= r_s1_ok ? w_s1_data : '0;
      r_err_id   <= r_err_id || (w_wr_fire && !w_wr_id_ok) || (w_rd_fire && !w_rd_id_ok);
      r_err_unf  <= r_err_unf || w_rd_unf;
      r_err_ovf  <= r_err_ovf || w_wr_ovf;
    end
  end

  assign o_wr_ready      = !i_clr_valid;
  assign o_rd_req_ready  = !i_clr_valid;
  assign o_rd_valid      = r_rd_valid;
  assign o_rd_last       = r_rd_last;
  assign o_rd_data       = r_rd_data;
  assign o_err_id        = r_err_id;
  assign o_err_underflow = r_err_unf;
  assign o_err_overflow  = r_err_ovf;

endmodule
